// File: rtl/csi2tx_clk_lane_ctrl.sv
// D-PHY clock-lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> HS clock entry,
// hold while data lanes need it, then post/trail/exit teardown back to LP-11.
module csi2tx_clk_lane_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             txclkesc,
  input  logic             txclkesc_rst,
  input  logic             hs_req,
  input  logic             cont_clk_mode,
  input  logic [CNT_W-1:0] t_lpx,
  input  logic [CNT_W-1:0] t_clk_prepare,
  input  logic [CNT_W-1:0] t_clk_zero,
  input  logic [CNT_W-1:0] t_clk_pre,
  input  logic [CNT_W-1:0] t_clk_post,
  input  logic [CNT_W-1:0] t_clk_trail,
  input  logic [CNT_W-1:0] t_hs_exit,
  output logic             clk_lp_p,
  output logic             clk_lp_n,
  output logic             clk_hs_drv_en,
  output logic             clk_hs_gate,
  output logic             clk_hs_rdy,
  output logic             clk_stopstate
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LPX    = 4'd1,
    PREP   = 4'd2,
    ZERO   = 4'd3,
    PRE    = 4'd4,
    ACTIVE = 4'd5,
    POST   = 4'd6,
    TRAIL  = 4'd7,
    EXIT   = 4'd8
  } state_t;

  // {lp_p, lp_n, drv_en, gate, rdy, stopstate}
  localparam logic [5:0] OUT_IDLE = 6'b110001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, cont_q;
  logic [5:0]       out_q, out_d;
  logic             capture;
  logic [CNT_W-1:0] sh_prep_q, sh_zero_q, sh_pre_q, sh_post_q, sh_trail_q, sh_exit_q;

  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  function automatic logic [5:0] decode(input state_t s);
    case (s)
      LPX:     decode = 6'b010000;
      PREP:    decode = 6'b000000;
      ZERO:    decode = 6'b001000;
      PRE:     decode = 6'b001100;
      ACTIVE:  decode = 6'b001110;
      POST:    decode = 6'b001100;
      TRAIL:   decode = 6'b001000;
      EXIT:    decode = 6'b110000;
      default: decode = OUT_IDLE;
    endcase
  endfunction

  always_comb begin
    logic done;
    logic [CNT_W-1:0] ld;
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ld      = '0;
    done    = (cnt_q == '0);
    case (state_q)
      IDLE:    if (req_q || cont_q) begin
                 state_d = LPX;
                 capture = 1'b1;
               end
      LPX:     if (done) state_d = PREP;
      PREP:    if (done) state_d = ZERO;
      ZERO:    if (done) state_d = PRE;
      PRE:     if (done) state_d = ACTIVE;
      ACTIVE:  if (!req_q && !cont_q) state_d = POST;
      POST:    if (done) state_d = TRAIL;
      TRAIL:   if (done) state_d = EXIT;
      EXIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // LPX loads from the live input since shadows are captured on the same edge
    case (state_d)
      LPX:     ld = load_val(t_lpx);
      PREP:    ld = load_val(sh_prep_q);
      ZERO:    ld = load_val(sh_zero_q);
      PRE:     ld = load_val(sh_pre_q);
      POST:    ld = load_val(sh_post_q);
      TRAIL:   ld = load_val(sh_trail_q);
      EXIT:    ld = load_val(sh_exit_q);
      default: ld = '0;
    endcase
    if (state_d != state_q) cnt_d = ld;
    else if (!done)         cnt_d = cnt_q - CNT_W'(1);
    out_d = decode(state_d);
  end

  always_ff @(posedge txclkesc or posedge txclkesc_rst) begin
    if (txclkesc_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cont_q  <= 1'b0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= hs_req;
      cont_q  <= cont_clk_mode;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge txclkesc) begin
    if (capture) begin
      sh_prep_q  <= t_clk_prepare;
      sh_zero_q  <= t_clk_zero;
      sh_pre_q   <= t_clk_pre;
      sh_post_q  <= t_clk_post;
      sh_trail_q <= t_clk_trail;
      sh_exit_q  <= t_hs_exit;
    end
  end

  assign clk_lp_p      = out_q[5];
  assign clk_lp_n      = out_q[4];
  assign clk_hs_drv_en = out_q[3];
  assign clk_hs_gate   = out_q[2];
  assign clk_hs_rdy    = out_q[1];
  assign clk_stopstate = out_q[0];

endmodule

// File: tb/tb_csi2tx_clk_lane_ctrl.sv
// Directed bench for csi2tx_clk_lane_ctrl: entry/exit timing, zero timings,
// continuous mode, shadowing, re-request and asynchronous reset.
module tb_csi2tx_clk_lane_ctrl;

  localparam int CNT_W = 8;
  // {lp_p, lp_n, drv_en, gate, rdy, stopstate}
  localparam logic [5:0] P_IDLE  = 6'b110001;
  localparam logic [5:0] P_LPX   = 6'b010000;
  localparam logic [5:0] P_PREP  = 6'b000000;
  localparam logic [5:0] P_ZERO  = 6'b001000;
  localparam logic [5:0] P_PRE   = 6'b001100;
  localparam logic [5:0] P_ACT   = 6'b001110;
  localparam logic [5:0] P_POST  = 6'b001100;
  localparam logic [5:0] P_TRAIL = 6'b001000;
  localparam logic [5:0] P_EXIT  = 6'b110000;

  logic clk = 1'b0;
  logic rst;
  logic hs_req, cont_clk_mode;
  logic [CNT_W-1:0] t_lpx, t_prep, t_zero, t_pre, t_post, t_trail, t_exit;
  logic lp_p, lp_n, drv_en, gate, rdy, stop;
  logic [5:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  assign outs = {lp_p, lp_n, drv_en, gate, rdy, stop};

  always #5 clk = ~clk;

  csi2tx_clk_lane_ctrl #(.CNT_W(CNT_W)) dut (
    .txclkesc      (clk),
    .txclkesc_rst  (rst),
    .hs_req        (hs_req),
    .cont_clk_mode (cont_clk_mode),
    .t_lpx         (t_lpx),
    .t_clk_prepare (t_prep),
    .t_clk_zero    (t_zero),
    .t_clk_pre     (t_pre),
    .t_clk_post    (t_post),
    .t_clk_trail   (t_trail),
    .t_hs_exit     (t_exit),
    .clk_lp_p      (lp_p),
    .clk_lp_n      (lp_n),
    .clk_hs_drv_en (drv_en),
    .clk_hs_gate   (gate),
    .clk_hs_rdy    (rdy),
    .clk_stopstate (stop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_t(input int a, input int b, input int c, input int d,
                       input int e, input int f, input int g);
    t_lpx = a[7:0]; t_prep = b[7:0]; t_zero = c[7:0]; t_pre = d[7:0];
    t_post = e[7:0]; t_trail = f[7:0]; t_exit = g[7:0];
  endtask

  task automatic wait_for(input logic [5:0] pat, input int max, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (outs == pat) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp;
    int rdy_cnt;
    int bad;
    rst = 1'b1; hs_req = 1'b0; cont_clk_mode = 1'b0;
    set_t(2, 3, 5, 4, 4, 3, 2);
    repeat (2) @(posedge clk);
    #1 check_eq("reset_idle", {26'd0, outs}, {26'd0, P_IDLE});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check_eq("post_reset_idle", {26'd0, outs}, {26'd0, P_IDLE});

    // Entry timing, with t_clk_zero changed during LPX to prove shadowing
    @(negedge clk) hs_req = 1'b1;
    @(posedge clk); #1 check_eq("entry_e0", {26'd0, outs}, {26'd0, P_IDLE});
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e <= 2)       exp = P_LPX;
      else if (e <= 5)  exp = P_PREP;
      else if (e <= 10) exp = P_ZERO;
      else if (e <= 14) exp = P_PRE;
      else              exp = P_ACT;
      check_eq($sformatf("entry_e%0d", e), {26'd0, outs}, {26'd0, exp});
      if (e == 1) t_zero = 8'd9;
    end
    t_zero = 8'd5;

    // Exit timing
    @(negedge clk) hs_req = 1'b0;
    @(posedge clk); #1 check_eq("exit_e0", {26'd0, outs}, {26'd0, P_ACT});
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      if (e <= 4)      exp = P_POST;
      else if (e <= 7) exp = P_TRAIL;
      else if (e <= 9) exp = P_EXIT;
      else             exp = P_IDLE;
      check_eq($sformatf("exit_e%0d", e), {26'd0, outs}, {26'd0, exp});
    end

    // Re-request raised during POST and held: one IDLE cycle then LPX
    @(negedge clk) hs_req = 1'b1;
    wait_for(P_ACT, 50, "rereq_reach_active");
    @(negedge clk) hs_req = 1'b0;
    @(posedge clk); #1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e <= 4)       exp = P_POST;
      else if (e <= 7)  exp = P_TRAIL;
      else if (e <= 9)  exp = P_EXIT;
      else if (e == 10) exp = P_IDLE;
      else              exp = P_LPX;
      check_eq($sformatf("rereq_e%0d", e), {26'd0, outs}, {26'd0, exp});
      if (e == 2) hs_req = 1'b1;
    end
    hs_req = 1'b0;
    wait_for(P_IDLE, 60, "rereq_return_idle");

    // All timings zero, single-cycle request pulse
    set_t(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) hs_req = 1'b1;
    @(posedge clk); #1 check_eq("zero_e0", {26'd0, outs}, {26'd0, P_IDLE});
    @(negedge clk) hs_req = 1'b0;
    rdy_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      case (e)
        1: exp = P_LPX;   2: exp = P_PREP; 3: exp = P_ZERO; 4: exp = P_PRE;
        5: exp = P_ACT;   6: exp = P_POST; 7: exp = P_TRAIL; 8: exp = P_EXIT;
        default: exp = P_IDLE;
      endcase
      check_eq($sformatf("zero_e%0d", e), {26'd0, outs}, {26'd0, exp});
      rdy_cnt += int'(rdy);
    end
    check_eq("zero_rdy_cycles", rdy_cnt, 32'd1);

    // Continuous clock mode
    set_t(1, 1, 1, 1, 1, 1, 1);
    @(negedge clk) cont_clk_mode = 1'b1;
    wait_for(P_ACT, 50, "cont_reach_active");
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (outs != P_ACT) bad++;
    end
    check_eq("cont_hold_bad_cycles", bad, 32'd0);
    @(negedge clk) cont_clk_mode = 1'b0;
    @(posedge clk); #1 check_eq("cont_drop_e0", {26'd0, outs}, {26'd0, P_ACT});
    @(posedge clk); #1 check_eq("cont_drop_e1", {26'd0, outs}, {26'd0, P_POST});
    wait_for(P_IDLE, 20, "cont_return_idle");

    // Asynchronous reset mid-ACTIVE
    @(negedge clk) cont_clk_mode = 1'b1;
    wait_for(P_ACT, 50, "rst_reach_active");
    @(posedge clk); #3 rst = 1'b1;
    #1 check_eq("rst_mid_active", {26'd0, outs}, {26'd0, P_IDLE});
    @(negedge clk) begin
      rst = 1'b0;
      cont_clk_mode = 1'b0;
    end
    @(posedge clk); #1 check_eq("rst_after_release", {26'd0, outs}, {26'd0, P_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
